// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: valid/ready boundary between two pipeline stages.
// The payload is opaque. An optional skid entry makes in_ready_o registered.
// A synchronous flush turns the stage into a bubble.
// A saturating counter records cycles in which downstream back-pressure held a valid payload.
module pipe_reg_elastic #(
  parameter int unsigned       DATA_W      = 101,
  parameter int unsigned       SKID        = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL  = {DATA_W{1'b0}},
  parameter int unsigned       STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [1:0]             count_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        main_q, main_d;
  logic [DATA_W-1:0]        skid_q, skid_d;
  logic                     vld_q;
  logic                     in_fire, out_fire, stall;
  logic [STALL_CNT_W-1:0]   stall_cnt_q;

  // The ready path depends on the mode. With a skid entry it is built only
  // from registered state and the flush gate. Without a skid entry it is
  // the usual pass-through of downstream ready.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready_o = (state_q != FULL) && !flush_i;
    end else begin : g_noskid
      assign in_ready_o = !flush_i && ((state_q == EMPTY) || out_ready_i);
    end
  endgenerate

  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = vld_q && out_ready_i;
  assign stall       = vld_q && !out_ready_i;

  assign out_valid_o = vld_q;
  assign out_data_o  = main_q;
  assign count_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

  // Next-state logic for the occupancy FSM and both data entries.
  // The main entry is reloaded with BUBBLE_VAL whenever it empties, so
  // out_data_o needs no output mux.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            // This case is unreachable without a skid entry, because input
            // fire then implies output fire.
            state_d = FULL;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State and data registers. out_valid_o gets its own flop so that it is a
  // pure register output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      vld_q   <= (state_d != EMPTY);
    end
  end

  // Saturating back-pressure counter. Flush does not clear it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic.
// Index 0 is a SKID=1 stage with a 4-bit stall counter.
// Index 1 is a SKID=0 stage with a 16-bit stall counter.
// A FIFO-occupancy model is checked on every negative edge, and the directed
// sequences add hand-computed literal checks.
module tb_pipe_reg_elastic;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [1:0]       flush, in_valid, out_ready, ready, ovld;
  logic [1:0][15:0] in_data, odata;
  logic [1:0][1:0]  cnt;
  logic [3:0]       stall_a;
  logic [15:0]      stall_b;

  int total = 0;
  int bad   = 0;

  pipe_reg_elastic #(.DATA_W(16), .SKID(1), .STALL_CNT_W(4)) u_skid (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(ovld[0]), .out_ready_i(out_ready[0]), .out_data_o(odata[0]),
    .count_o(cnt[0]), .stall_cnt_o(stall_a));

  pipe_reg_elastic #(.DATA_W(16), .SKID(0), .STALL_CNT_W(16)) u_noskid (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(ovld[1]), .out_ready_i(out_ready[1]), .out_data_o(odata[1]),
    .count_o(cnt[1]), .stall_cnt_o(stall_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: each stage is a FIFO of depth 2 (SKID=1) or 1 (SKID=0).
  logic [15:0] mq [2][2];
  int          msz [2];
  int          mst [2];

  function automatic logic model_rdy(input int d);
    if (flush[d]) return 1'b0;
    if (d == 0) return msz[0] < 2;
    return (msz[1] == 0) || out_ready[1];
  endfunction

  // Compare process: check outputs, then advance the model to the state after the next edge.
  always begin : cmp
    logic        mr, inf, outf;
    logic [15:0] st;
    @(negedge clk_i);
    if (rst_i) begin
      msz[0] = 0; msz[1] = 0; mst[0] = 0; mst[1] = 0;
    end
    for (int d = 0; d < 2; d++) begin
      st = (d == 0) ? {12'b0, stall_a} : stall_b;
      chk($sformatf("m%0d_vld", d),   ovld[d],  msz[d] > 0);
      chk($sformatf("m%0d_data", d),  odata[d], (msz[d] > 0) ? mq[d][0] : 16'h0);
      chk($sformatf("m%0d_cnt", d),   cnt[d],   msz[d]);
      chk($sformatf("m%0d_rdy", d),   ready[d], model_rdy(d));
      chk($sformatf("m%0d_stall", d), st,       mst[d]);
    end
    if (!rst_i) begin
      for (int d = 0; d < 2; d++) begin
        mr   = model_rdy(d);
        inf  = in_valid[d] && mr;
        outf = (msz[d] > 0) && out_ready[d];
        if ((msz[d] > 0) && !out_ready[d] && (mst[d] < ((d == 0) ? 15 : 65535))) mst[d]++;
        if (flush[d]) begin
          msz[d] = 0;
        end else begin
          if (outf) begin mq[d][0] = mq[d][1]; msz[d]--; end
          if (inf)  begin mq[d][msz[d]] = in_data[d]; msz[d]++; end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush = '0; in_valid = '0; out_ready = '0; in_data = '0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("rst_rdy", ready[0], 1'b1);
    chk("rst_cnt", cnt[0], 2'd0);
    chk("rst_vld", ovld[0], 1'b0);

    // Streaming through the skid stage
    out_ready[0] = 1'b1; in_valid[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data[0] = 16'(i);
      tick;
      chk("stream_data", odata[0], i);
      chk("stream_cnt", cnt[0], 2'd1);
    end
    chk("stream_stall", stall_a, 4'd0);
    in_valid[0] = 1'b0;
    tick;
    chk("stream_drain", cnt[0], 2'd0);

    // Back-pressure: A, B fill the stage, C is held off
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 16'hA;
    tick;
    in_data[0] = 16'hB;
    tick;
    chk("bp_cnt_full", cnt[0], 2'd2);
    chk("bp_rdy_low", ready[0], 1'b0);
    in_data[0] = 16'hC;
    tick; tick;
    chk("bp_stall3", stall_a, 4'd3);
    chk("bp_head_a", odata[0], 16'hA);
    out_ready[0] = 1'b1;
    tick;
    chk("bp_out_b", odata[0], 16'hB);
    chk("bp_cnt1", cnt[0], 2'd1);
    tick;
    chk("bp_out_c", odata[0], 16'hC);
    in_valid[0] = 1'b0;
    tick;
    chk("bp_empty", ovld[0], 1'b0);
    chk("bp_stall_hold", stall_a, 4'd3);

    // Flush while full, with an input offered in the same cycle
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 16'h1;
    tick;
    in_data[0] = 16'h2;
    tick;
    chk("fl_full", cnt[0], 2'd2);
    flush[0] = 1'b1; in_data[0] = 16'hD;
    #1;
    chk("fl_rdy_low", ready[0], 1'b0);
    tick;
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    chk("fl_vld", ovld[0], 1'b0);
    chk("fl_data", odata[0], 16'h0);
    chk("fl_cnt", cnt[0], 2'd0);
    chk("fl_stall", stall_a, 4'd5);
    out_ready[0] = 1'b1;
    tick; tick;

    // No-skid stage: combinational ready from out_ready
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 16'h11;
    tick;
    chk("ns_vld", ovld[1], 1'b1);
    chk("ns_data1", odata[1], 16'h11);
    in_data[1] = 16'h22;
    #1;
    chk("ns_rdy_low", ready[1], 1'b0);
    tick;
    chk("ns_hold", odata[1], 16'h11);
    out_ready[1] = 1'b1;
    #1;
    chk("ns_rdy_comb", ready[1], 1'b1);
    tick;
    chk("ns_data2", odata[1], 16'h22);
    in_data[1] = 16'h33;
    tick;
    chk("ns_data3", odata[1], 16'h33);
    in_valid[1] = 1'b0;
    tick;
    chk("ns_empty", cnt[1], 2'd0);
    chk("ns_stall", stall_b, 16'd1);

    // Saturation of the 4-bit stall counter
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 16'h55;
    tick;
    in_valid[0] = 1'b0;
    repeat (20) tick;
    chk("sat_max", stall_a, 4'd15);
    chk("sat_data", odata[0], 16'h55);
    flush[0] = 1'b1;
    tick;
    flush[0] = 1'b0;
    chk("sat_flush_keep", stall_a, 4'd15);
    chk("sat_flush_cnt", cnt[0], 2'd0);

    // Asynchronous reset mid-cycle with a payload held
    in_valid[0] = 1'b1; in_data[0] = 16'h66;
    tick;
    in_data[0] = 16'h77;
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_vld", ovld[0], 1'b0);
    chk("ar_data", odata[0], 16'h0);
    chk("ar_cnt", cnt[0], 2'd0);
    chk("ar_rdy", ready[0], 1'b1);
    chk("ar_stall_a", stall_a, 4'd0);
    chk("ar_stall_b", stall_b, 16'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; in_valid[0] = 1'b0;
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
